// File: rtl/bus_cycle_unit.sv
// Multiplexed address/data bus cycle engine: turns core requests into
// T1/T2/TW/T3/T4 bus cycles with wait states, wait timeout and bus hold.
module bus_cycle_unit #(
    parameter int AW       = 16,
    parameter int DW       = 8,
    parameter int MAX_WAIT = 15
) (
    input  logic             phi1,
    input  logic             resetn_in,
    input  logic             req,
    input  logic [2:0]       op,
    input  logic [AW-1:0]    addr,
    input  logic [DW-1:0]    wdata,
    output logic             ack,
    output logic             err,
    output logic [DW-1:0]    rdata,
    output logic [AW-DW-1:0] haddress,
    output logic [DW-1:0]    ad_out,
    output logic             ad_oe,
    input  logic [DW-1:0]    ad_in,
    output logic             ale,
    output logic             S0,
    output logic             S1,
    output logic             IOMn,
    output logic             RDn,
    output logic             WRn,
    input  logic             ready,
    input  logic             hold,
    output logic             hlda,
    output logic             bus_float
);

    localparam int WCW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WCW-1:0] WAIT_LIM = WCW'(MAX_WAIT);
    localparam logic [WCW-1:0] WAIT_SAT = {WCW{1'b1}};
    localparam logic [WCW-1:0] WAIT_ONE = WCW'(1);
    localparam logic [WCW-1:0] WAIT_ZERO = {WCW{1'b0}};

    localparam logic [2:0] OP_FETCH = 3'b000;
    localparam logic [2:0] OP_MRD   = 3'b001;
    localparam logic [2:0] OP_MWR   = 3'b010;
    localparam logic [2:0] OP_IORD  = 3'b011;
    localparam logic [2:0] OP_IOWR  = 3'b100;
    localparam logic [2:0] OP_INTA  = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_TW   = 3'd3,
        ST_T3   = 3'd4,
        ST_T4   = 3'd5,
        ST_HOLD = 3'd6
    } state_t;

    // Status pins {S1,S0,IOMn} for each legal cycle type.
    function automatic logic [2:0] status_of(input logic [2:0] op_v);
        logic [2:0] st;
        case (op_v)
            OP_FETCH: st = 3'b110;
            OP_MRD:   st = 3'b100;
            OP_MWR:   st = 3'b010;
            OP_IORD:  st = 3'b101;
            OP_IOWR:  st = 3'b011;
            OP_INTA:  st = 3'b111;
            default:  st = 3'b000;
        endcase
        return st;
    endfunction

    function automatic logic op_legal(input logic [2:0] op_v);
        return (op_v <= OP_INTA);
    endfunction

    function automatic logic is_read(input logic [2:0] op_v);
        return (op_v == OP_FETCH) || (op_v == OP_MRD) ||
               (op_v == OP_IORD)  || (op_v == OP_INTA);
    endfunction

    // Fetch and interrupt acknowledge carry an extra idle T4 state.
    function automatic logic has_t4(input logic [2:0] op_v);
        return (op_v == OP_FETCH) || (op_v == OP_INTA);
    endfunction

    state_t            state_q, state_d;
    logic [1:0]        rst_sync_q, rst_sync_d;
    logic [2:0]        op_q, op_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [WCW-1:0]    wcnt_q, wcnt_d, wcnt_inc;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic [AW-DW-1:0]  haddr_q, haddr_d;
    logic [DW-1:0]     ad_out_q, ad_out_d;
    logic              ad_oe_q, ad_oe_d;
    logic              ale_q, ale_d;
    logic              s0_q, s0_d;
    logic              s1_q, s1_d;
    logic              iomn_q, iomn_d;
    logic              rdn_q, rdn_d;
    logic              wrn_q, wrn_d;
    logic              hlda_q, hlda_d;
    logic              float_q, float_d;

    assign wcnt_inc = (wcnt_q == WAIT_SAT) ? wcnt_q : (wcnt_q + WAIT_ONE);

    // Next-state and next-output computation for the bus cycle FSM.
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
        state_d    = state_q;
        op_d       = op_q;
        wdata_d    = wdata_q;
        wcnt_d     = wcnt_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        rdata_d    = rdata_q;
        haddr_d    = haddr_q;
        ad_out_d   = ad_out_q;
        ad_oe_d    = ad_oe_q;
        ale_d      = 1'b0;
        s1_d       = s1_q;
        s0_d       = s0_q;
        iomn_d     = iomn_q;
        rdn_d      = rdn_q;
        wrn_d      = wrn_q;
        hlda_d     = 1'b0;
        float_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                rdn_d   = 1'b1;
                wrn_d   = 1'b1;
                ad_oe_d = 1'b0;
                if (!rst_sync_q[1]) begin
                    state_d = ST_IDLE;
                end else if (hold) begin
                    state_d = ST_HOLD;
                    hlda_d  = 1'b1;
                    float_d = 1'b1;
                end else if (req && !ack_q) begin
                    // The ack cycle never accepts, so a held req cannot re-trigger.
                    if (op_legal(op)) begin
                        state_d  = ST_T1;
                        op_d     = op;
                        wdata_d  = wdata;
                        wcnt_d   = WAIT_ZERO;
                        {s1_d, s0_d, iomn_d} = status_of(op);
                        ale_d    = 1'b1;
                        ad_oe_d  = 1'b1;
                        ad_out_d = addr[DW-1:0];
                        haddr_d  = addr[AW-1:DW];
                    end else begin
                        ack_d = 1'b1;
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_T1: begin
                state_d = ST_T2;
                wcnt_d  = WAIT_ZERO;
                if (is_read(op_q)) begin
                    rdn_d   = 1'b0;
                    ad_oe_d = 1'b0;
                end else begin
                    wrn_d    = 1'b0;
                    ad_oe_d  = 1'b1;
                    ad_out_d = wdata_q;
                end
            end
            ST_T2: begin
                if (ready) begin
                    state_d = ST_T3;
                end else begin
                    state_d = ST_TW;
                    wcnt_d  = wcnt_inc;
                end
            end
            ST_TW: begin
                // wcnt_q counts the TW states entered so far, this one included.
                if (ready) begin
                    state_d = ST_T3;
                end else if ((MAX_WAIT != 0) && (wcnt_q == WAIT_LIM)) begin
                    state_d = ST_IDLE;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    rdn_d   = 1'b1;
                    wrn_d   = 1'b1;
                    ad_oe_d = 1'b0;
                end else begin
                    wcnt_d = wcnt_inc;
                end
            end
            ST_T3: begin
                if (is_read(op_q)) begin
                    rdata_d = ad_in;
                end else begin
                    rdata_d = rdata_q;
                end
                if (has_t4(op_q)) begin
                    state_d = ST_T4;
                    rdn_d   = 1'b1;
                    ad_oe_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                    ack_d   = 1'b1;
                    rdn_d   = 1'b1;
                    wrn_d   = 1'b1;
                    ad_oe_d = 1'b0;
                end
            end
            ST_T4: begin
                state_d = ST_IDLE;
                ack_d   = 1'b1;
                rdn_d   = 1'b1;
                wrn_d   = 1'b1;
                ad_oe_d = 1'b0;
            end
            ST_HOLD: begin
                ad_oe_d = 1'b0;
                if (hold) begin
                    hlda_d  = 1'b1;
                    float_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                rdn_d   = 1'b1;
                wrn_d   = 1'b1;
                ad_oe_d = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge phi1 or negedge resetn_in) begin
        if (!resetn_in) begin
            state_q    <= ST_IDLE;
            rst_sync_q <= 2'b00;
            op_q       <= 3'b000;
            wdata_q    <= {DW{1'b0}};
            wcnt_q     <= WAIT_ZERO;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= {DW{1'b0}};
            haddr_q    <= {(AW-DW){1'b0}};
            ad_out_q   <= {DW{1'b0}};
            ad_oe_q    <= 1'b0;
            ale_q      <= 1'b0;
            s1_q       <= 1'b0;
            s0_q       <= 1'b0;
            iomn_q     <= 1'b0;
            rdn_q      <= 1'b1;
            wrn_q      <= 1'b1;
            hlda_q     <= 1'b0;
            float_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_sync_q <= rst_sync_d;
            op_q       <= op_d;
            wdata_q    <= wdata_d;
            wcnt_q     <= wcnt_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            haddr_q    <= haddr_d;
            ad_out_q   <= ad_out_d;
            ad_oe_q    <= ad_oe_d;
            ale_q      <= ale_d;
            s1_q       <= s1_d;
            s0_q       <= s0_d;
            iomn_q     <= iomn_d;
            rdn_q      <= rdn_d;
            wrn_q      <= wrn_d;
            hlda_q     <= hlda_d;
            float_q    <= float_d;
        end
    end

    assign ack       = ack_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign haddress  = haddr_q;
    assign ad_out    = ad_out_q;
    assign ad_oe     = ad_oe_q;
    assign ale       = ale_q;
    assign S1        = s1_q;
    assign S0        = s0_q;
    assign IOMn      = iomn_q;
    assign RDn       = rdn_q;
    assign WRn       = wrn_q;
    assign hlda      = hlda_q;
    assign bus_float = float_q;

endmodule

// File: tb/tb_bus_cycle_unit.sv
// Scoreboard bench for bus_cycle_unit: random and directed bus cycles,
// a bus-slave responder, and a monitor that checks each ack against a model.
module tb_bus_cycle_unit;

    localparam int MAXW = 3;

    logic        phi1 = 1'b0;
    logic        resetn_in = 1'b1;
    logic        req = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [15:0] addr = 16'd0;
    logic [7:0]  wdata = 8'd0;
    logic        ack, err;
    logic [7:0]  rdata;
    logic [7:0]  haddress;
    logic [7:0]  ad_out;
    logic        ad_oe;
    logic [7:0]  ad_in = 8'd0;
    logic        ale, S0, S1, IOMn, RDn, WRn;
    logic        ready = 1'b1;
    logic        hold = 1'b0;
    logic        hlda, bus_float;

    bus_cycle_unit #(.AW(16), .DW(8), .MAX_WAIT(MAXW)) dut (
        .phi1(phi1), .resetn_in(resetn_in), .req(req), .op(op), .addr(addr),
        .wdata(wdata), .ack(ack), .err(err), .rdata(rdata), .haddress(haddress),
        .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in), .ale(ale), .S0(S0),
        .S1(S1), .IOMn(IOMn), .RDn(RDn), .WRn(WRn), .ready(ready), .hold(hold),
        .hlda(hlda), .bus_float(bus_float)
    );

    always #5 phi1 = ~phi1;

    typedef struct {
        logic        illegal;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        err;
        logic [7:0]  rdata;
        logic [2:0]  stat;
        int          lat;
        int          strobes;
        int          issue;
    } exp_t;

    exp_t        q[$];
    exp_t        me;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          cur_w = 0;
    logic [7:0]  cur_rdat = 8'd0;
    logic [7:0]  last_rdata = 8'd0;
    int          slv_k = 0;
    int          strobe_n = 0;

    always @(posedge phi1) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, expv);
        end
    endtask

    function automatic logic [2:0] stat_tbl(input logic [2:0] o);
        case (o)
            3'd0:    return 3'b110;
            3'd1:    return 3'b100;
            3'd2:    return 3'b010;
            3'd3:    return 3'b101;
            3'd4:    return 3'b011;
            3'd5:    return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    // Reference model: expected completion of one request given w wait cycles.
    task automatic push_exp(input logic [2:0] o, input logic [15:0] a, input logic [7:0] d,
                            input int w, input logic [7:0] rd);
        exp_t e;
        bit rd_type, long_c, tmo;
        e.illegal = (o > 3'd5);
        rd_type   = (o == 3'd0) || (o == 3'd1) || (o == 3'd3) || (o == 3'd5);
        long_c    = (o == 3'd0) || (o == 3'd5);
        tmo       = !e.illegal && (w > MAXW);
        e.addr    = a;
        e.wdata   = d;
        e.stat    = stat_tbl(o);
        e.err     = e.illegal || tmo;
        if (e.illegal) begin
            e.lat = 1; e.strobes = 0;
        end else if (tmo) begin
            e.lat = 3 + MAXW; e.strobes = 1 + MAXW;
        end else begin
            e.lat = (long_c ? 5 : 4) + w; e.strobes = 2 + w;
        end
        if (!e.illegal && !tmo && rd_type) last_rdata = rd;
        e.rdata  = last_rdata;
        e.issue  = cyc;
        cur_w    = w;
        cur_rdat = rd;
        q.push_back(e);
    endtask

    task automatic scramble();
        op    = 3'($urandom);
        addr  = 16'($urandom);
        wdata = 8'($urandom);
    endtask

    task automatic wait_ack();
        int n;
        n = 0;
        while (!ack && n < 60) begin
            @(negedge phi1);
            n++;
        end
        if (!ack) begin
            chk("ack_wait", {63'd0, ack}, 64'd1);
            q.delete();
        end
        req = 1'b0;
        @(negedge phi1);
    endtask

    task automatic do_txn(input logic [2:0] o, input logic [15:0] a, input logic [7:0] d,
                          input int w, input logic [7:0] rd);
        op = o; addr = a; wdata = d; req = 1'b1;
        push_exp(o, a, d, w, rd);
        @(negedge phi1);
        scramble();
        wait_ack();
    endtask

    task automatic chk_reset(input string name);
        chk(name, {ack, err, rdata, ad_out, ad_oe, haddress, ale, RDn, WRn, S1, S0, IOMn, hlda, bus_float},
            {1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    endtask

    // Bus slave: holds ready low for the first cur_w strobe cycles.
    always @(negedge phi1) begin
        ad_in = cur_rdat;
        if (!RDn || !WRn) begin
            ready = (slv_k >= cur_w);
            slv_k++;
        end else begin
            ready = 1'b1;
            slv_k = 0;
        end
    end

    // Monitor: bus-phase checks plus scoreboard pop on every ack.
    always @(negedge phi1) begin
        if (!resetn_in) begin
            strobe_n = 0;
        end else begin
            if (ale) begin
                if (q.size() == 0) begin
                    chk("ale_unexpected", {63'd0, ale}, 64'd0);
                end else begin
                    chk("ale_on_illegal", {63'd0, q[0].illegal}, 64'd0);
                    chk("t1_ad_out", ad_out, q[0].addr[7:0]);
                    chk("t1_haddress", haddress, q[0].addr[15:8]);
                    chk("t1_ad_oe", ad_oe, 1);
                    chk("t1_status", {S1, S0, IOMn}, q[0].stat);
                end
            end
            if (!RDn || !WRn) begin
                strobe_n++;
                if (q.size() != 0) begin
                    if (!WRn) begin
                        chk("wr_excl", RDn, 1);
                        chk("wr_ad_oe", ad_oe, 1);
                        chk("wr_data", ad_out, q[0].wdata);
                    end else begin
                        chk("rd_ad_oe", ad_oe, 0);
                    end
                end
            end
            if (ack) begin
                if (q.size() == 0) begin
                    chk("ack_unexpected", {63'd0, ack}, 64'd0);
                end else begin
                    me = q.pop_front();
                    chk("latency", cyc - me.issue, me.lat);
                    chk("err", err, me.err);
                    chk("rdata", rdata, me.rdata);
                    chk("strobe_cycles", strobe_n, me.strobes);
                    chk("ack_status", {S1, S0, IOMn}, me.illegal ? {S1, S0, IOMn} : me.stat);
                end
                strobe_n = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=time_limit required=finish");
        $fatal(1);
    end

    initial begin
        int w_r;
        #2 resetn_in = 1'b0;
        #1 chk_reset("reset_state");
        repeat (3) @(negedge phi1);
        chk_reset("reset_hold");
        resetn_in = 1'b1;
        repeat (3) @(negedge phi1);

        // Directed scenarios.
        do_txn(3'd1, 16'h12A4, 8'h00, 0, 8'h5C);
        do_txn(3'd4, 16'h0033, 8'h7E, 2, 8'h00);
        do_txn(3'd0, 16'h2000, 8'h00, 0, 8'hC3);
        do_txn(3'd0, 16'h2001, 8'h00, 0, 8'h3C);
        do_txn(3'd1, 16'h0100, 8'h00, 9, 8'hEE);
        do_txn(3'd5, 16'h0000, 8'h00, 1, 8'h21);
        do_txn(3'd6, 16'h1111, 8'h22, 0, 8'h00);
        do_txn(3'd2, 16'hFF00, 8'h81, MAXW, 8'h00);

        // Hold raised mid-cycle: current read completes, then HOLD.
        op = 3'd1; addr = 16'h4321; wdata = 8'h00; req = 1'b1;
        push_exp(3'd1, 16'h4321, 8'h00, 0, 8'h9D);
        @(negedge phi1);
        scramble();
        @(negedge phi1);
        hold = 1'b1;
        wait_ack();
        chk("hold_hlda", hlda, 1);
        chk("hold_float", bus_float, 1);
        chk("hold_ad_oe", ad_oe, 0);
        op = 3'd3; addr = 16'h0456; wdata = 8'h00; req = 1'b1;
        repeat (2) @(negedge phi1);
        chk("hold_stay", hlda, 1);
        chk("hold_no_ale", ale, 0);
        hold = 1'b0;
        @(negedge phi1);
        chk("hold_rel_hlda", hlda, 0);
        chk("hold_rel_float", bus_float, 0);
        push_exp(3'd3, 16'h0456, 8'h00, 1, 8'h3B);
        @(negedge phi1);
        scramble();
        wait_ack();

        // Asynchronous reset while in a wait state.
        op = 3'd1; addr = 16'hBEEF; wdata = 8'h00; req = 1'b1;
        push_exp(3'd1, 16'hBEEF, 8'h00, 20, 8'h11);
        @(negedge phi1);
        @(negedge phi1);
        @(negedge phi1);
        #2 resetn_in = 1'b0;
        req = 1'b0;
        #1 chk("rst_tw_rdn", RDn, 1);
        chk("rst_tw_ad_oe", ad_oe, 0);
        chk("rst_tw_ack", ack, 0);
        q.delete();
        last_rdata = 8'h00;
        chk_reset("reset_mid");
        repeat (2) begin
            @(negedge phi1);
            chk("rst_no_ack", ack, 0);
        end
        resetn_in = 1'b1;
        repeat (3) @(negedge phi1);
        do_txn(3'd7, 16'h5555, 8'hAA, 0, 8'h00);

        // Randomised traffic.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) w_r = $urandom_range(MAXW + 1, MAXW + 3);
            else w_r = $urandom_range(0, MAXW);
            do_txn(3'($urandom_range(0, 7)), 16'($urandom), 8'($urandom), w_r, 8'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge phi1);
        end

        repeat (3) @(negedge phi1);
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_cycle_unit.md
BUS_CYCLE_UNIT -- requirements
Module: bus_cycle_unit

Interface
REQ-001 Parameter: AW, 16, total address width; SHALL satisfy AW > DW.
REQ-002 Parameter: DW, 8, data width; also the width of the multiplexed low address/data bus.
REQ-003 Parameter: MAX_WAIT, 15, maximum consecutive TW states before abort; 0 disables the timeout.
REQ-004 Ports: phi1 in 1 clock, rising edge; resetn_in in 1 reset, asynchronous, active-low.
REQ-005 Ports: req in 1 core request, level; op in 3 cycle type; addr in AW; wdata in DW.
REQ-006 Ports: ack out 1 one-cycle completion; err out 1 abort/illegal flag, valid with ack; rdata out DW read data, valid with ack.
REQ-007 Ports: haddress out AW-DW upper address; ad_out out DW; ad_oe out 1 drive enable; ad_in in DW sampled pads.
REQ-008 Ports: ale out 1; S0 out 1; S1 out 1; IOMn out 1; RDn out 1; WRn out 1; ready in 1 wait request (0 = wait).
REQ-009 Ports: hold in 1 bus request; hlda out 1 hold acknowledge; bus_float out 1 tristate request for IOMn/RDn/WRn/haddress/ad pads.

Function
REQ-010 op encoding: 000 fetch, 001 mem read, 010 mem write, 011 io read, 100 io write, 101 intack, 110/111 illegal.
REQ-011 States: IDLE, T1, T2, TW, T3, T4, HOLD; all outputs registered.
REQ-012 IDLE: ale=0, RDn=WRn=1, ad_oe=0; S1,S0,IOMn hold last value.
REQ-013 IDLE priority: hold=1 -> HOLD; else req=1 and ack=0 -> latch op/addr/wdata, -> T1; else stay.
REQ-014 Illegal op accepted in IDLE: no bus activity; next cycle ack=1, err=1; state stays IDLE.
REQ-015 Status from T1 through end of cycle (S1,S0,IOMn): fetch 1,1,0; mem read 1,0,0; mem write 0,1,0; io read 1,0,1; io write 0,1,1; intack 1,1,1.
REQ-016 T1: ale=1; ad_oe=1; ad_out=addr[DW-1:0]; haddress=addr[AW-1:DW]; -> T2.
REQ-017 T2: ale=0; read-type (fetch, mem/io read, intack): RDn=0, ad_oe=0; write-type: WRn=0, ad_oe=1, ad_out=wdata; ready=1 -> T3, ready=0 -> TW.
REQ-018 TW: strobes, ad_out, ad_oe unchanged; wait counter increments; ready=1 -> T3.
REQ-019 TW timeout: MAX_WAIT != 0 and counter reaches MAX_WAIT while ready=0 -> RDn=WRn=1, ad_oe=0, -> IDLE, ack=1, err=1, rdata unchanged.
REQ-020 Wait counter: width $clog2(MAX_WAIT+1); cleared in T1; saturates, never wraps.
REQ-021 T3: strobe held; read-type captures ad_in into rdata on the edge leaving T3.
REQ-022 T3 exit: fetch and intack -> T4 (RDn=1, ad_oe=0, no bus activity); others -> IDLE.
REQ-023 Exit to IDLE from T3/T4: ack=1, err=0 for exactly one cycle; the ack cycle never accepts req.
REQ-024 Latency with ready=1: mem/io read/write = 4 cycles req-accept to ack; fetch/intack = 5; each TW adds 1.
REQ-025 Back-to-back: req held high -> next T1 starts the cycle after the ack cycle.
REQ-026 hold is sampled only in IDLE; an in-progress cycle completes first.
REQ-027 HOLD: hlda=1, bus_float=1, ad_oe=0, ale=0; hold=0 -> IDLE with hlda=0 and bus_float=0 on the same edge.
REQ-028 req, addr, op and wdata changes after acceptance SHALL NOT affect the current cycle.

Reset
REQ-029 resetn_in=0 SHALL asynchronously force IDLE with ack=0, err=0, rdata=0, ad_out=0, ad_oe=0, haddress=0, ale=0, RDn=WRn=1, S1=S0=0, IOMn=0, hlda=0, bus_float=0, and wait counter=0.
REQ-030 Reset during any state, including TW or HOLD, aborts the cycle with no ack; after release, operation starts from IDLE.
REQ-031 Reset deassertion is synchronised internally to phi1; the first possible req acceptance is the first rising edge after synchronisation.

Verification
REQ-032 Mem read: addr=0x12A4, ready=1, ad_in=0x5C in T3 -> ale pulse in T1 with ad_out=0xA4, haddress=0x12; RDn low in T2-T3; ack on cycle 4 with rdata=0x5C, err=0.
REQ-033 IO write: addr=0x0033, wdata=0x7E, ready=0 for 2 cycles -> S1,S0,IOMn=0,1,1; WRn low for 4 cycles; ad_out=0x7E; ack on cycle 6.
REQ-034 Fetch back-to-back: two fetches, req held -> T1,T2,T3,T4,ack/IDLE,T1...; S1=S0=1; ack spacing 5 cycles.
REQ-035 Timeout: MAX_WAIT=3, ready=0 forever -> exactly 3 TW, then RDn=1, ack=1, err=1; rdata unchanged.
REQ-036 Hold during read: hold asserted in T2 -> read completes and acks, HOLD is entered on the following edge, hlda=1; hold=0 -> hlda=0, and a pending req starts T1 next.
REQ-037 Async reset in TW: resetn_in low mid-cycle -> RDn=1, ad_oe=0 immediately, no ack; op=111 afterwards -> ack=1, err=1, no ale.
